// File: rtl/dma_copia_mem_if.sv
// dma_copia_mem_if: control and memory-bus bundle for the byte copy engine.
// master = engine side, slave = requester/memory side.
interface dma_copia_mem_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic [15:0]      src_addr;
  logic [15:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err;
  logic [15:0]      mem_addr;
  logic             mem_we;
  logic [7:0]       mem_din;
  logic [7:0]       mem_dout;
  logic [3:0]       mem_cs;

  modport master (
    input  start, src_addr, dst_addr, len,
    input  mem_dout, mem_cs,
    output busy, done, err,
    output mem_addr, mem_we, mem_din
  );

  modport slave (
    output start, src_addr, dst_addr, len,
    output mem_dout, mem_cs,
    input  busy, done, err,
    input  mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/dma_copia_mem.sv
// dma_copia_mem: byte copy engine, one read then one write per byte.
// Define DMA_CHECK_CS_EN to abort when mem_cs is not one-hot.
module dma_copia_mem #(
  parameter int RD_LAT = 2,
  parameter int LEN_W  = 11
) (
  input logic             clk,
  input logic             rst_n,
  dma_copia_mem_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, FIN
  } state_t;

  localparam logic [2:0] RL = 3'(RD_LAT);

  state_t           state, state_n;
  logic [15:0]      src_q, dst_q;
  logic [LEN_W-1:0] len_q, idx, idx_inc;
  logic [2:0]       rcnt;
  logic [7:0]       data_q;
  logic             err_q;
  logic             last_rd;
  logic             cs_ok;
  logic [15:0]      off;

  assign idx_inc = idx + LEN_W'(1);
  assign last_rd = (rcnt == RL);
  assign off     = 16'(idx);

`ifdef DMA_CHECK_CS_EN
  logic abort;
  assign cs_ok = $onehot(bus.mem_cs);
  assign abort = !cs_ok &&
                 ((state == READ && last_rd) ||
                  state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (state == IDLE && bus.start)
      err_q <= 1'b0;
    else if (abort)
      err_q <= 1'b1;
  end
`else
  assign cs_ok = 1'b1;
  assign err_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.start)
          state_n = (bus.len != '0) ? READ : FIN;
      READ:
        if (last_rd)
          state_n = cs_ok ? WRITE : FIN;
      WRITE:
        if (cs_ok && idx_inc < len_q)
          state_n = READ;
        else
          state_n = FIN;
      FIN:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx    <= '0;
      rcnt   <= '0;
      data_q <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.start) begin
            src_q <= bus.src_addr;
            dst_q <= bus.dst_addr;
            len_q <= bus.len;
            idx   <= '0;
            rcnt  <= '0;
          end
        READ: begin
          rcnt <= last_rd ? 3'd0 : rcnt + 3'd1;
          if (last_rd) data_q <= bus.mem_dout;
        end
        WRITE:
          idx <= idx_inc;
        FIN: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = (state == FIN);
    bus.err      = err_q;
    bus.mem_we   = (state == WRITE) && cs_ok;
    bus.mem_din  = bus.mem_we ? data_q : 8'h00;
    bus.mem_addr = 16'h0000;
    unique case (1'b1)
      state == READ:  bus.mem_addr = src_q + off;
      state == WRITE: bus.mem_addr = dst_q + off;
      default:        bus.mem_addr = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_dma_copia_mem.sv
// tb_dma_copia_mem: table vectors, random copies and reset sequences
// checked against a byte-array copy model.
module tb_dma_copia_mem;
  localparam int RD_LAT = 2;
  localparam int LEN_W  = 11;
  localparam int PER    = RD_LAT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_copia_mem_if #(.LEN_W(LEN_W)) bus();

  dma_copia_mem #(
    .RD_LAT(RD_LAT),
    .LEN_W (LEN_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic [15:0] pipe    [4];
  logic [15:0] rd_log  [$];
  logic [15:0] wr_log  [$];

  int total = 0;
  int bad = 0;
  int viol = 0;
  int we_cnt = 0;

  function automatic logic unmapped(logic [15:0] a);
    return a[15:12] == 4'h8;
  endfunction

  // memory system: fixed read latency, decoder on addr[15:14]
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    pipe[0] <= bus.mem_addr;
    for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
  end

  assign bus.mem_dout = mem[pipe[RD_LAT-1]];
  assign bus.mem_cs = unmapped(bus.mem_addr) ? 4'b0000 :
                      (4'b0001 << bus.mem_addr[15:14]);

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) we_cnt++;
      if (!bus.mem_we && bus.mem_din != 8'h00) viol++;
      if (!bus.busy &&
          (bus.mem_addr != 16'h0 || bus.mem_we || bus.done))
        viol++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic model(input logic [15:0] s,
                       input logic [15:0] d,
                       input int n,
                       output int cyc,
                       output logic e,
                       output int nwr);
    e = 1'b0;
    nwr = 0;
    cyc = n * PER + 1;
    for (int i = 0; i < n; i++) begin
`ifdef DMA_CHECK_CS_EN
      if (unmapped(s + 16'(i))) begin
        e = 1'b1;
        cyc = i * PER + RD_LAT + 2;
        return;
      end
      if (unmapped(d + 16'(i))) begin
        e = 1'b1;
        cyc = i * PER + PER + 1;
        return;
      end
`endif
      ref_mem[d + 16'(i)] = ref_mem[s + 16'(i)];
      nwr++;
    end
  endtask

  // exp_cyc < 0: take cycle count and err from the model
  task automatic xfer(input logic [15:0] s,
                      input logic [15:0] d,
                      input int n,
                      input int poke,
                      input int exp_cyc,
                      input logic exp_e);
    int mc, nwr, cyc, ec, exp_rd, rd_bad, wr_bad;
    logic me, e, got_done, prev_rd;
    model(s, d, n, mc, me, nwr);
    ec = (exp_cyc < 0) ? mc : exp_cyc;
    if (exp_cyc < 0) exp_e = me;
    rd_log.delete();
    wr_log.delete();
    bus.start = 1'b1;
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.len = LEN_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_addr = 16'($urandom);
    bus.dst_addr = 16'($urandom);
    bus.len = LEN_W'($urandom);
    cyc = 0;
    e = 1'b0;
    got_done = 1'b0;
    prev_rd = 1'b0;
    for (int k = 0; k < 8000 && !got_done; k++) begin
      if (bus.busy) cyc++;
      if (bus.busy && !bus.done && !bus.mem_we && !prev_rd)
        rd_log.push_back(bus.mem_addr);
      prev_rd = bus.busy && !bus.done && !bus.mem_we;
      if (bus.mem_we) wr_log.push_back(bus.mem_addr);
      if (bus.done) begin
        got_done = 1'b1;
        e = bus.err;
      end else begin
        if (k == poke) begin
          bus.start = 1'b1;
          bus.src_addr = s ^ 16'h5a5a;
          bus.dst_addr = d ^ 16'h0f0f;
          bus.len = LEN_W'(1);
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("busy_cycles", cyc, ec);
    chk("err_at_done", 32'(e), 32'(exp_e));
    @(negedge clk);
    chk("idle_after", {bus.busy, bus.done}, 32'd0);
    exp_rd = e ? nwr + 1 : n;
    chk("rd_count", rd_log.size(), exp_rd);
    chk("wr_count", wr_log.size(), nwr);
    rd_bad = 0;
    wr_bad = 0;
    foreach (rd_log[i])
      if (rd_log[i] != s + 16'(i)) rd_bad++;
    foreach (wr_log[i])
      if (wr_log[i] != d + 16'(i)) wr_bad++;
    chk("rd_order", rd_bad, 0);
    chk("wr_order", wr_bad, 0);
    chk("mem_image", mem_diffs(), 0);
  endtask

  typedef struct {
    logic [15:0] s;
    logic [15:0] d;
    int          n;
    int          poke;
    int          cyc;
    logic        e;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] v;
    int we0;
    bus.start = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len = '0;

    tbl[0] = '{16'h0000, 16'h0400, 3, -1, 13, 1'b0};
    tbl[1] = '{16'h0100, 16'h0700, 0, -1, 1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h1000, 2, -1, 9, 1'b0};
    tbl[3] = '{16'h2000, 16'h2001, 4, -1, 17, 1'b0};
`ifdef DMA_CHECK_CS_EN
    tbl[4] = '{16'h8000, 16'h0500, 2, -1, 4, 1'b1};
    tbl[6] = '{16'h0600, 16'h8100, 1, -1, 5, 1'b1};
`else
    tbl[4] = '{16'h8000, 16'h0500, 2, -1, 9, 1'b0};
    tbl[6] = '{16'h0600, 16'h8100, 1, -1, 5, 1'b0};
`endif
    tbl[5] = '{16'h3000, 16'h3100, 5, 3, 21, 1'b0};
    tbl[7] = '{16'h4000, 16'h5000, 1024, -1, 4097, 1'b0};

    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      if (i == 0) v = 8'hAA;
      if (i == 1) v = 8'hBB;
      if (i == 2) v = 8'hCC;
      mem[i] <= v;
      ref_mem[i] = v;
    end

    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_din", 32'(bus.mem_din), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[t]) begin
      xfer(tbl[t].s, tbl[t].d, tbl[t].n, tbl[t].poke,
           tbl[t].cyc, tbl[t].e);
      if (t == 0) begin
        chk("copy_b0", 32'(mem[16'h0400]), 32'hAA);
        chk("copy_b1", 32'(mem[16'h0401]), 32'hBB);
        chk("copy_b2", 32'(mem[16'h0402]), 32'hCC);
      end
    end

    for (int r = 0; r < 12; r++)
      xfer(16'($urandom), 16'($urandom),
           int'($urandom_range(1, 40)),
           (r % 3 == 0) ? int'($urandom_range(0, 6)) : -1,
           -1, 1'b0);

    // abandon a copy during its first read
    bus.start = 1'b1;
    bus.src_addr = 16'h0700;
    bus.dst_addr = 16'h0800;
    bus.len = LEN_W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    we0 = we_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs",
        {bus.busy, bus.done, bus.err, bus.mem_we,
         bus.mem_addr, bus.mem_din}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_we_after_rst", we_cnt, we0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("mem_after_rst", mem_diffs(), 0);

    xfer(16'h0010, 16'h0900, 2, -1, -1, 1'b0);
    chk("invariants", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_copia_mem.md
DMA_COPIA_MEM -- requirements
Module: dma_copia_mem

Interface
REQ-001 Parameter RD_LAT, 2, memory read latency in clk cycles from address-valid to mem_dout-valid (legal range 1..4).
REQ-002 Parameter LEN_W, 11, width of len port (max transfer 1024 bytes).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  input  16  first source byte address; sampled on accepted start.
REQ-007 dst_addr  input  16  first destination byte address; sampled on accepted start.
REQ-008 len  input  LEN_W  byte count; sampled on accepted start.
REQ-009 busy  output  1  high from the cycle after accepted start until the done cycle, inclusive.
REQ-010 done  output  1  one-cycle pulse at end of transfer (normal or aborted).
REQ-011 err  output  1  set with done on abort; held until next accepted start.
REQ-012 mem_addr  output  16  address to memory system.
REQ-013 mem_we  output  1  write enable to memory system.
REQ-014 mem_din  output  8  write data to memory system.
REQ-015 mem_dout  input  8  read data from memory system.
REQ-016 mem_cs  input  4  chip-select vector from memory-system decoder (one-hot when address mapped).

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, FIN.
REQ-018 IDLE: start=1 and len!=0 -> READ, latching src/dst/len, clearing byte counter and err.
REQ-019 IDLE: start=1 and len==0 -> FIN with no memory access; done asserted next cycle.
REQ-020 start while not IDLE SHALL be ignored, with no effect on the transfer in progress.
REQ-021 READ: mem_addr=src+i, mem_we=0, held stable RD_LAT+1 cycles; mem_dout captured into a data register at the end of the last READ cycle.
REQ-022 WRITE: one cycle, mem_addr=dst+i, mem_we=1, mem_din=captured byte; then i+1; -> READ if i+1<len, else FIN.
REQ-023 Each byte SHALL take exactly RD_LAT+2 cycles; busy spans len*(RD_LAT+2) cycles, plus one FIN cycle.
REQ-024 FIN: done=1 for one cycle, busy=1, -> IDLE.
REQ-025 Address arithmetic SHALL be 16-bit modulo; 0xFFFF+1 wraps to 0x0000 with no error.
REQ-026 Overlapping src/dst ranges SHALL be copied in ascending address order with no special handling.
REQ-027 mem_we SHALL be 1 only in WRITE; mem_din SHALL be 0 outside WRITE.
REQ-028 In IDLE, mem_addr=0 and mem_we=0.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_din=0, and clear counter and registers.
REQ-030 Reset mid-transfer SHALL abandon the copy with no further write; bytes already written remain.
REQ-031 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro DMA_CHECK_CS_EN: when defined, the block SHALL check mem_cs at each read capture and at each WRITE cycle; if it is not one-hot, the block SHALL perform no write, go to FIN, and assert err=1 with done.
REQ-033 Without DMA_CHECK_CS_EN, mem_cs SHALL be ignored and err SHALL be tied 0.

Verification
REQ-034 Reset: rst_n=0 mid-READ -> all outputs 0 asynchronously; no mem_we pulse after release.
REQ-035 Copy: RD_LAT=2, src=0x0000 holding AA,BB,CC, dst=0x0400, len=3 -> 0x0400..0x0402 = AA,BB,CC; busy 13 cycles; done on the 13th cycle.
REQ-036 len=0 with start -> done one cycle later; mem_we never asserted; err=0.
REQ-037 Wrap: src=0xFFFF, len=2 -> reads 0xFFFF then 0x0000; writes dst, dst+1.
REQ-038 start pulsed while busy with a different src -> ignored; the original transfer completes unchanged.
REQ-039 With DMA_CHECK_CS_EN, src in unmapped range (mem_cs=0000) -> no write, done=1, err=1; without the macro, the copy completes and err=0.
